// File: rtl/wb_axi_pkg.sv
// Shared definitions for the Wishbone-to-AXI4-Lite path: default bus geometry
// and the arbiter state encoding.
package wb_axi_pkg;

    localparam int NM_DEFAULT = 4;
    localparam int DW_DEFAULT = 32;
    localparam int AW_DEFAULT = 32;

    typedef logic state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans from (last+1) mod NM, wraps through
// all NM requesters and returns the first hit as a one-hot vector.
module rr_pick #(
    parameter int NM = 4,
    parameter int LW = 2
) (
    input  logic [NM-1:0] req,
    input  logic [LW-1:0] last,
    output logic [NM-1:0] gnt
);

    logic          found;
    logic [LW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NM; i++) begin
            idx = LW'((int'(last) + i) % NM);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave port, the grant is
// held for a whole cyc and always followed by one idle cycle.
module wb_rr_arbiter
    import wb_axi_pkg::*;
#(
    parameter int NM = NM_DEFAULT,
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic [NM*AW-1:0]   m_adr_i,
    input  logic [NM*DW-1:0]   m_dat_i,
    input  logic [NM*DW/8-1:0] m_sel_i,
    input  logic [NM-1:0]      m_we_i,
    input  logic [NM-1:0]      m_cyc_i,
    input  logic [NM-1:0]      m_stb_i,
    output logic [DW-1:0]      m_dat_o,
    output logic [NM-1:0]      m_ack_o,
    output logic [NM-1:0]      m_err_o,
    output logic [NM-1:0]      m_rty_o,
    output logic [AW-1:0]      s_adr_o,
    output logic [DW-1:0]      s_dat_o,
    output logic [DW/8-1:0]    s_sel_o,
    output logic               s_we_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    input  logic [DW-1:0]      s_dat_i,
    input  logic               s_ack_i,
    input  logic               s_err_i,
    input  logic               s_rty_i,
    output logic [NM-1:0]      gnt_o
);

    localparam int LW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = DW / 8;

    state_t        state_q, state_d;
    logic [NM-1:0] gnt_q, gnt_d;
    logic [LW-1:0] last_q, last_d;
    logic [NM-1:0] pick;
    logic [LW-1:0] gnt_idx;
    logic          any_req;
    logic          owner_cyc;
    logic          busy;

    rr_pick #(
        .NM (NM),
        .LW (LW)
    ) u_rr_pick (
        .req  (m_cyc_i),
        .last (last_q),
        .gnt  (pick)
    );

    assign any_req   = |m_cyc_i;
    assign owner_cyc = |(gnt_q & m_cyc_i);
    assign busy      = (state_q == ST_BUSY);

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NM; k++) begin
            if (gnt_q[k]) begin
                gnt_idx = LW'(k);
            end
        end
    end

    // Reset leaves last at NM-1 so the first scan begins at master 0.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= LW'(NM - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_BUSY;
                    gnt_d   = pick;
                end
            end
            ST_BUSY: begin
                if (!owner_cyc) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    last_d  = gnt_idx;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (busy) begin
            for (int k = 0; k < NM; k++) begin
                if (gnt_q[k]) begin
                    s_adr_o = m_adr_i[k*AW +: AW];
                    s_dat_o = m_dat_i[k*DW +: DW];
                    s_sel_o = m_sel_i[k*SW +: SW];
                    s_we_o  = m_we_i[k];
                    s_cyc_o = m_cyc_i[k];
                    s_stb_o = m_cyc_i[k] & m_stb_i[k];
                end
            end
        end
    end

    // Responses are qualified by the live grant, so anything arriving in IDLE is dropped.
    assign m_ack_o = (busy && s_ack_i) ? gnt_q : '0;
    assign m_err_o = (busy && s_err_i) ? gnt_q : '0;
    assign m_rty_o = (busy && s_rty_i) ? gnt_q : '0;
    assign m_dat_o = s_dat_i;
    assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a grant-owner model checked on every
// falling edge, plus literal expectations for each scenario.
module tb_wb_rr_arbiter;

    localparam int NM = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic               clk;
    logic               rst_n;
    logic [NM*AW-1:0]   m_adr;
    logic [NM*DW-1:0]   m_dat;
    logic [NM*SW-1:0]   m_sel;
    logic [NM-1:0]      m_we, m_cyc, m_stb;
    logic [DW-1:0]      m_dat_out;
    logic [NM-1:0]      m_ack, m_err, m_rty;
    logic [AW-1:0]      s_adr;
    logic [DW-1:0]      s_dat_out;
    logic [SW-1:0]      s_sel;
    logic               s_we, s_cyc, s_stb;
    logic [DW-1:0]      s_dat;
    logic               s_ack, s_err, s_rty;
    logic [NM-1:0]      gnt;

    int vectors = 0;
    int errors  = 0;

    wb_rr_arbiter #(.NM(NM), .DW(DW), .AW(AW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .m_adr_i    (m_adr),
        .m_dat_i    (m_dat),
        .m_sel_i    (m_sel),
        .m_we_i     (m_we),
        .m_cyc_i    (m_cyc),
        .m_stb_i    (m_stb),
        .m_dat_o    (m_dat_out),
        .m_ack_o    (m_ack),
        .m_err_o    (m_err),
        .m_rty_o    (m_rty),
        .s_adr_o    (s_adr),
        .s_dat_o    (s_dat_out),
        .s_sel_o    (s_sel),
        .s_we_o     (s_we),
        .s_cyc_o    (s_cyc),
        .s_stb_o    (s_stb),
        .s_dat_i    (s_dat),
        .s_ack_i    (s_ack),
        .s_err_i    (s_err),
        .s_rty_i    (s_rty),
        .gnt_o      (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (-1 = nobody) and who owned it last.
    int owner = -1;
    int last  = NM - 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner = -1;
            last  = NM - 1;
        end else if (owner < 0) begin
            for (int i = 1; i <= NM; i++) begin
                if (owner < 0 && m_cyc[(last + i) % NM]) owner = (last + i) % NM;
            end
        end else if (!m_cyc[owner]) begin
            last  = owner;
            owner = -1;
        end
    end

    task automatic check_model(input string tag);
        logic [NM-1:0] eg;
        logic          b;
        b  = (owner >= 0);
        eg = b ? NM'(1 << owner) : '0;
        chk({tag, ".gnt"}, 64'(gnt), 64'(eg));
        chk({tag, ".s_cyc"}, 64'(s_cyc), 64'(b && m_cyc[owner]));
        chk({tag, ".s_stb"}, 64'(s_stb), 64'(b && m_cyc[owner] && m_stb[owner]));
        chk({tag, ".s_we"}, 64'(s_we), 64'(b && m_we[owner]));
        chk({tag, ".s_adr"}, 64'(s_adr), b ? 64'(m_adr[owner*AW +: AW]) : 64'd0);
        chk({tag, ".s_dat"}, 64'(s_dat_out), b ? 64'(m_dat[owner*DW +: DW]) : 64'd0);
        chk({tag, ".s_sel"}, 64'(s_sel), b ? 64'(m_sel[owner*SW +: SW]) : 64'd0);
        chk({tag, ".m_ack"}, 64'(m_ack), 64'(s_ack ? eg : '0));
        chk({tag, ".m_err"}, 64'(m_err), 64'(s_err ? eg : '0));
        chk({tag, ".m_rty"}, 64'(m_rty), 64'(s_rty ? eg : '0));
        chk({tag, ".m_dat"}, 64'(m_dat_out), 64'(s_dat));
    endtask

    always @(negedge clk) check_model("model");

    // Grant history recorder for the fairness scenario.
    bit            rec = 0;
    int            gseq[$];
    int            gaps[$];
    int            idle_run = 0;
    logic [NM-1:0] prev_gnt = '0;

    always @(negedge clk) begin
        if (rec) begin
            if (gnt == '0) idle_run++;
            else if (gnt != prev_gnt) begin
                for (int k = 0; k < NM; k++) if (gnt[k]) gseq.push_back(k);
                if (gseq.size() > 1) gaps.push_back(idle_run);
                idle_run = 0;
            end
            prev_gnt = gnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_masters();
        m_cyc = '0; m_stb = '0; m_we = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic do_reset();
        clear_masters();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0;
        s_dat = '0;
        clear_masters();
        for (int k = 0; k < NM; k++) begin
            m_adr[k*AW +: AW] = 32'h1000 * (k + 1);
            m_dat[k*DW +: DW] = 32'hD000_0000 + k;
            m_sel[k*SW +: SW] = SW'(k + 1);
        end
        do_reset();
        chk("reset_gnt", 64'(gnt), 64'd0);
        chk("reset_s_cyc", 64'(s_cyc), 64'd0);

        // Single read from master 0
        m_adr[0 +: AW] = 32'h10;
        m_cyc = 4'b0001; m_stb = 4'b0001;
        tick();
        chk("rd0_gnt", 64'(gnt), 64'h1);
        chk("rd0_adr", 64'(s_adr), 64'h10);
        s_ack = 1'b1; s_dat = 32'hCAFE_F00D;
        #1;
        chk("rd0_ack", 64'(m_ack), 64'h1);
        chk("rd0_dat", 64'(m_dat_out), 64'hCAFE_F00D);
        tick();
        clear_masters();
        tick();
        tick();

        // Four continuous requesters, each finishing after one granted cycle
        do_reset();
        rec = 1;
        m_cyc = 4'b1111; m_stb = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            tick();
            m_cyc = ~gnt;
            m_stb = ~gnt;
        end
        rec = 0;
        clear_masters();
        chk("rr_count", 64'(gseq.size() >= 5), 64'd1);
        if (gseq.size() >= 5) begin
            chk("rr_g0", 64'(gseq[0]), 64'd0);
            chk("rr_g1", 64'(gseq[1]), 64'd1);
            chk("rr_g2", 64'(gseq[2]), 64'd2);
            chk("rr_g3", 64'(gseq[3]), 64'd3);
            chk("rr_g4", 64'(gseq[4]), 64'd0);
            for (int i = 0; i < 4; i++) chk("rr_gap", 64'(gaps[i]), 64'd1);
        end
        tick();

        // Master 2 bursts three beats while master 1 waits
        do_reset();
        m_cyc = 4'b0100; m_stb = 4'b0100;
        tick();
        m_cyc = 4'b0110; m_stb = 4'b0110;
        for (int b = 0; b < 3; b++) begin
            s_ack = 1'b1;
            #1;
            chk("burst_gnt", 64'(gnt), 64'h4);
            chk("burst_ack", 64'(m_ack), 64'h4);
            tick();
            s_ack = 1'b0;
        end
        m_cyc = 4'b0010; m_stb = 4'b0010;
        tick();
        chk("burst_gap", 64'(gnt), 64'h0);
        tick();
        chk("burst_next", 64'(gnt), 64'h2);
        clear_masters();
        tick();
        tick();

        // Error + retry on a write from master 3
        do_reset();
        m_cyc = 4'b1000; m_stb = 4'b1000; m_we = 4'b1000;
        m_dat[3*DW +: DW] = 32'h1234_5678;
        m_sel[3*SW +: SW] = 4'hF;
        tick();
        s_err = 1'b1; s_rty = 1'b1;
        #1;
        chk("wr3_err", 64'(m_err), 64'h8);
        chk("wr3_rty", 64'(m_rty), 64'h8);
        chk("wr3_ack", 64'(m_ack), 64'h0);
        chk("wr3_we", 64'(s_we), 64'h1);
        chk("wr3_dat", 64'(s_dat_out), 64'h1234_5678);
        chk("wr3_sel", 64'(s_sel), 64'hF);
        tick();
        clear_masters();
        tick();
        tick();

        // Reset pulse in the middle of master 1's read
        do_reset();
        m_cyc = 4'b0010; m_stb = 4'b0010;
        tick();
        chk("rst_pre_gnt", 64'(gnt), 64'h2);
        rst_n = 1'b0;
        s_ack = 1'b1;
        #1;
        chk("rst_s_cyc", 64'(s_cyc), 64'h0);
        chk("rst_s_stb", 64'(s_stb), 64'h0);
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_ack", 64'(m_ack), 64'h0);
        tick();
        rst_n = 1'b1;
        s_ack = 1'b0;
        m_cyc = 4'b0011; m_stb = 4'b0011;
        #1;
        chk("rst_release_gnt", 64'(gnt), 64'h0);
        tick();
        chk("rst_next", 64'(gnt), 64'h1);
        clear_masters();
        tick();
        tick();

        // Stray slave ack while idle
        s_ack = 1'b1; s_err = 1'b1;
        #1;
        chk("stray_ack", 64'(m_ack), 64'h0);
        chk("stray_err", 64'(m_err), 64'h0);
        tick();
        chk("stray_ack2", 64'(m_ack), 64'h0);
        clear_masters();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
